// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
// Programmable VGA timing generator. A divider turns clk_50 into a one-cycle
// pixel-tick enable. On each tick the horizontal and vertical counters advance.
// The pixel coordinates are registered one tick after the counter state. The
// sync, video-on and frame-start flags are delayed by a further PIPE_DELAY
// ticks, which gives the downstream colour pipeline a fixed latency to match.
//
// Ports
//   clk_50         : system clock, rising edge
//   rst            : asynchronous reset, active low
//   pix_ce         : pixel-tick enable, one clk_50 cycle per pixel
//   pixel_column   : horizontal count of the current tick
//   pixel_row      : vertical count of the current tick
//   horiz_sync_out : delayed hsync, active level SYNC_POL
//   vert_sync_out  : delayed vsync, active level SYNC_POL
//   video_on       : delayed active-area flag
//   frame_start    : one-cycle pulse aligned with the delayed (0,0) pixel
//   frame_count    : completed frames, wraps modulo 2^16
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 2,
    parameter int CW         = 11
) (
    input  logic          clk_50,
    input  logic          rst,
    output logic          pix_ce,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic          horiz_sync_out,
    output logic          vert_sync_out,
    output logic          video_on,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Flag vector bit positions; all-zero is the inactive (reset) vector.
    localparam int B_ACT   = 0;
    localparam int B_HS    = 1;
    localparam int B_VS    = 2;
    localparam int B_FIRST = 3;

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [15:0]   fc_q, fc_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [3:0]    vec0_q, vec0_d;
    logic [3:0]    vec_out;
    logic [3:0]    dec;
    logic          h_wrap;
    logic          v_wrap;

    // With CLK_DIV=1 DIV_LAST is zero, so the enable is high even in reset.
    assign pix_ce = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_comb begin
        dec          = '0;
        dec[B_ACT]   = (h_q < H_ACT) && (v_q < V_ACT);
        dec[B_HS]    = (h_q >= HS_BEG) && (h_q < HS_END);
        dec[B_VS]    = (v_q >= VS_BEG) && (v_q < VS_END);
        dec[B_FIRST] = (h_q == '0) && (v_q == '0);
    end

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d    = h_q;
        v_d    = v_q;
        fc_d   = fc_q;
        col_d  = col_q;
        row_d  = row_q;
        vec0_d = vec0_q;
        if (pix_ce) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
                if (v_wrap) begin
                    fc_d = fc_q + 16'd1;
                end
            end
            col_d  = h_q;
            row_d  = v_q;
            vec0_d = dec;
        end
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            fc_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            vec0_q <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fc_q   <= fc_d;
            col_q  <= col_d;
            row_q  <= row_d;
            vec0_q <= vec0_d;
        end
    end

    // Flag delay line. With no extra delay the stage-0 vector drives the
    // outputs directly, so flags line up with the coordinates.
    if (PIPE_DELAY == 0) begin : g_nopipe
        assign vec_out = vec0_q;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0][3:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (pix_ce) begin
                pipe_d[0] = vec0_q;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_50 or negedge rst) begin
            if (!rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign vec_out = pipe_q[PIPE_DELAY-1];
    end

    assign pixel_column   = col_q;
    assign pixel_row      = row_q;
    assign frame_count    = fc_q;
    assign video_on       = vec_out[B_ACT];
    assign horiz_sync_out = vec_out[B_HS] ? SYNC_POL : ~SYNC_POL;
    assign vert_sync_out  = vec_out[B_VS] ? SYNC_POL : ~SYNC_POL;
    // The first flag is held for a whole tick; gating with the enable keeps
    // the pulse to a single clk_50 cycle.
    assign frame_start    = vec_out[B_FIRST] & pix_ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Testbench for vga_timing_gen. Four instances with different parameter sets
// share one clock and reset. Expected outputs come from an arithmetic model
// indexed by the number of clk_50 edges since reset release.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int d, pd;
        bit pol;
    } cfg_t;

    typedef struct {
        bit pce, hs, vs, von, fs;
        int col, row, fc;
    } exp_t;

    logic clk_50 = 1'b0;
    logic rst    = 1'b0;
    int   c      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    cfg_t cfg_def, cfg_sml, cfg_med, cfg_p7;

    always #5 clk_50 = ~clk_50;

    logic d_pce, d_hs, d_vs, d_von, d_fs; logic [10:0] d_col, d_row; logic [15:0] d_fc;
    logic s_pce, s_hs, s_vs, s_von, s_fs; logic [10:0] s_col, s_row; logic [15:0] s_fc;
    logic m_pce, m_hs, m_vs, m_von, m_fs; logic [10:0] m_col, m_row; logic [15:0] m_fc;
    logic p_pce, p_hs, p_vs, p_von, p_fs; logic [10:0] p_col, p_row; logic [15:0] p_fc;

    vga_timing_gen u_def (
        .clk_50(clk_50), .rst(rst), .pix_ce(d_pce),
        .pixel_column(d_col), .pixel_row(d_row),
        .horiz_sync_out(d_hs), .vert_sync_out(d_vs),
        .video_on(d_von), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CLK_DIV(1), .PIPE_DELAY(0)
    ) u_sml (
        .clk_50(clk_50), .rst(rst), .pix_ce(s_pce),
        .pixel_column(s_col), .pixel_row(s_row),
        .horiz_sync_out(s_hs), .vert_sync_out(s_vs),
        .video_on(s_von), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b0), .CLK_DIV(2), .PIPE_DELAY(3)
    ) u_med (
        .clk_50(clk_50), .rst(rst), .pix_ce(m_pce),
        .pixel_column(m_col), .pixel_row(m_row),
        .horiz_sync_out(m_hs), .vert_sync_out(m_vs),
        .video_on(m_von), .frame_start(m_fs), .frame_count(m_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .CLK_DIV(3), .PIPE_DELAY(7)
    ) u_p7 (
        .clk_50(clk_50), .rst(rst), .pix_ce(p_pce),
        .pixel_column(p_col), .pixel_row(p_row),
        .horiz_sync_out(p_hs), .vert_sync_out(p_vs),
        .video_on(p_von), .frame_start(p_fs), .frame_count(p_fc)
    );

    // Outputs after `cyc` edges since release: k ticks have completed, the
    // coordinates show tick k-1 and the flags show tick k-1-pd, where tick n
    // sits at raster position n mod (H_TOTAL*V_TOTAL).
    function automatic exp_t model(input cfg_t g, input int cyc, input bit in_rst);
        exp_t e;
        int ht, vt, f, k, j, p, h, v;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        f  = ht * vt;
        e.pce = (g.d == 1);
        e.col = 0; e.row = 0; e.fc = 0;
        e.hs = !g.pol; e.vs = !g.pol; e.von = 1'b0; e.fs = 1'b0;
        if (!in_rst) begin
            k = cyc / g.d;
            e.pce = ((cyc % g.d) == g.d - 1);
            if (k > 0) begin
                p = (k - 1) % f;
                e.col = p % ht;
                e.row = p / ht;
            end
            j = k - 1 - g.pd;
            if (j >= 0) begin
                p = j % f;
                h = p % ht;
                v = p / ht;
                e.von = (h < g.ha) && (v < g.va);
                if (h >= g.ha + g.hf && h < g.ha + g.hf + g.hs) e.hs = g.pol;
                if (v >= g.va + g.vf && v < g.va + g.vf + g.vs) e.vs = g.pol;
                e.fs = (p == 0) && e.pce;
            end
            e.fc = (k / f) % 65536;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", tag, obs, exp, c, $time);
        end
    endtask

    task automatic check_inst(input string nm, input cfg_t g, input logic pce,
                              input logic [10:0] col, input logic [10:0] row,
                              input logic hs, input logic vs, input logic von,
                              input logic fs, input logic [15:0] fc);
        exp_t e;
        e = model(g, c, !rst);
        chk({nm, ".pix_ce"}, pce, e.pce);
        chk({nm, ".col"},    col, e.col);
        chk({nm, ".row"},    row, e.row);
        chk({nm, ".hsync"},  hs,  e.hs);
        chk({nm, ".vsync"},  vs,  e.vs);
        chk({nm, ".von"},    von, e.von);
        chk({nm, ".fstart"}, fs,  e.fs);
        chk({nm, ".fcount"}, fc,  e.fc);
    endtask

    task automatic check_all();
        check_inst("def", cfg_def, d_pce, d_col, d_row, d_hs, d_vs, d_von, d_fs, d_fc);
        check_inst("sml", cfg_sml, s_pce, s_col, s_row, s_hs, s_vs, s_von, s_fs, s_fc);
        check_inst("med", cfg_med, m_pce, m_col, m_row, m_hs, m_vs, m_von, m_fs, m_fc);
        check_inst("p7",  cfg_p7,  p_pce, p_col, p_row, p_hs, p_vs, p_von, p_fs, p_fc);
    endtask

    task automatic step();
        @(posedge clk_50);
        if (rst) c++;
        @(negedge clk_50);
        check_all();
    endtask

    initial begin
        int ticks, von_cnt, hsl_cnt, n, off, hold;
        cfg_def = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0};
        cfg_sml = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 0, 1'b1};
        cfg_med = '{40, 4, 6, 5, 20, 3, 2, 4, 2, 3, 1'b0};
        cfg_p7  = '{12, 2, 3, 3, 6, 1, 2, 1, 3, 7, 1'b1};

        // Reset held for 10 cycles.
        rst = 1'b0;
        c   = 0;
        repeat (10) step();
        chk("def.rst_hsync", d_hs, 1);
        chk("def.rst_vsync", d_vs, 1);
        chk("def.rst_von",   d_von, 0);
        chk("def.rst_col",   d_col, 0);

        // Release and observe the first default line.
        rst = 1'b1;
        c   = 0;
        #1 check_all();
        ticks = 0; von_cnt = 0; hsl_cnt = 0;
        repeat (1600) begin
            step();
            if (d_pce) begin
                ticks++;
                if (d_von) von_cnt++;
                if (!d_hs) hsl_cnt++;
            end
        end
        chk("def.line_ticks", ticks, 800);
        chk("def.line_von",   von_cnt, 640);
        chk("def.line_hslow", hsl_cnt, 96);

        // Two complete medium frames (1595 ticks each at 2 cycles per tick).
        while (c < 7000) step();
        chk("med.two_frames", m_fc, 2);

        // Random run lengths, each ended by an asynchronous mid-cycle reset.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(100, 4000);
            repeat (n) step();
            off = $urandom_range(1, 3);
            #(off);
            rst = 1'b0;
            c   = 0;
            #1 check_all();
            @(negedge clk_50);
            check_all();
            hold = $urandom_range(0, 4);
            repeat (hold) step();
            rst = 1'b1;
            #1 check_all();
        end
        repeat (200) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: the next-generation replacement for the fixed 640x480 controller. Divides `clk_50` down to a pixel-clock enable, runs horizontal and vertical counters with fully programmable active, porch and sync intervals and sync polarity, and outputs pixel coordinates plus delayed sync and blanking. The delay gives the downstream colour or character-lookup pipeline a fixed number of pixel ticks to produce RGB that lines up with the syncs. It sits between `clk_50`/`rst` and the pixel renderer / VGA connector.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `SYNC_POL`, 0: sync active level (0 = active-low)
- `CLK_DIV`, 2: `clk_50` cycles per pixel tick (≥1)
- `PIPE_DELAY`, 2: extra pixel ticks of delay on syncs/video_on relative to coordinates (0..7)
- `CW`, 11: counter/coordinate width
- `clk_50` in 1: system clock; every register is clocked on its rising edge
- `rst` in 1: asynchronous, active-low reset
- `pix_ce` out 1: pixel-tick enable, high for one `clk_50` cycle per pixel
- `pixel_column` out CW: horizontal count of the current tick (0..H_TOTAL-1)
- `pixel_row` out CW: vertical count of the current tick (0..V_TOTAL-1)
- `horiz_sync_out` out 1: delayed hsync
- `vert_sync_out` out 1: delayed vsync
- `video_on` out 1: delayed active-area flag
- `frame_start` out 1: one-`clk_50` pulse aligned with the delayed (0,0) pixel
- `frame_count` out 16: number of completed frames, wraps modulo 2^16

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be < 2^CW.
- Divider:
  - `div` counts 0..CLK_DIV-1 on every `clk_50`.
  - `pix_ce` = (div == CLK_DIV-1).
  - With CLK_DIV=1, `pix_ce` is constantly 1 after reset.
- Counters advance only on `pix_ce`:
  - `h` increments and wraps H_TOTAL-1 -> 0.
  - On the h wrap, `v` increments and wraps V_TOTAL-1 -> 0.
  - On the simultaneous h and v wrap, `frame_count` increments.
- Decode of (h,v), registered as stage 0 on `pix_ce`:
  - act = h<H_ACTIVE && v<V_ACTIVE.
  - hs_act = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
  - first = (h==0 && v==0).
- Stage 0 loads `pixel_column`/`pixel_row` = (h,v).
- Stage 0 also loads the {act, hs_act, vs_act, first} vector into a shift register of depth PIPE_DELAY, advanced only on `pix_ce`.
- The shift-register output drives the delayed outputs:
  - `video_on` = act.
  - `horiz_sync_out` = hs_act ? SYNC_POL : ~SYNC_POL.
  - `vert_sync_out` = vs_act ? SYNC_POL : ~SYNC_POL.
  - `frame_start` = first && `pix_ce` (one `clk_50` cycle wide).
- PIPE_DELAY=0: the vector bypasses the shift register, so the delayed outputs are coincident with the coordinates.

## Timing
- Reset (`rst`=0) sets, immediately and asynchronously:
  - div, h, v, `frame_count`, `pixel_column`, `pixel_row` = 0.
  - `video_on` = 0, `frame_start` = 0, `pix_ce` = 0 (except CLK_DIV=1, where it is 1).
  - Both syncs = ~SYNC_POL; every shift-register stage holds the inactive vector.
- First `pix_ce` arrives on the CLK_DIV-th rising edge after `rst` deasserts.
- Coordinate latency: counter state (h,v) at tick n appears on `pixel_column`/`pixel_row` after tick n.
- Sync/video_on/frame_start latency: the same state appears PIPE_DELAY ticks after the coordinates (1+PIPE_DELAY ticks after the counter state).
- Every output except `frame_start` and `pix_ce` changes only on `clk_50` edges where `pix_ce`=1, and holds otherwise.
- Reset mid-frame: all state returns to the reset values above; no partial sync pulse is extended; the first post-reset frame starts at (0,0).
- `frame_count` 0xFFFF + 1 -> 0x0000 with no flag.

## Test plan
- Defaults, reset held 10 cycles then released:
  - During reset: syncs=1, `video_on`=0, coordinates 0.
  - After release: first `pix_ce` on the 2nd edge; `pixel_column`=0 after the 1st tick; `video_on` rises 2 ticks later.
- Defaults, one line:
  - 800 ticks per line; `video_on` high 640 consecutive ticks.
  - `horiz_sync_out` low exactly 96 ticks, starting 2 ticks after `pixel_column`=656.
- Defaults, full frame:
  - `vert_sync_out` low during delayed lines 490-491 only.
  - `frame_start` pulses once every 840000 `clk_50` cycles; `frame_count` 0 -> 1 -> 2 over two frames.
- Small parameter set (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, SYNC_POL=1, PIPE_DELAY=0):
  - hsync high at `pixel_column` 9-10.
  - vsync high on row 5.
  - 12x7 ticks per frame.
- PIPE_DELAY sweep 0, 3, 7: the `video_on` rising edge trails `pixel_column`=0 (row 0) by exactly 0, 3 and 7 ticks.
- `rst` pulsed low at h=700, v=300:
  - All outputs drop to reset values in the same cycle.
  - After release, the sequence matches the first test.
